// File: rtl/aes128_arbiter.sv
// aes128_arbiter: two-requester round-robin front end sharing one AES-128 core.
// Define AES128_ARB_TIMEOUT_EN to compile in the WAIT-state timeout counter.
module aes128_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [1:0]   req0_op_i,
  input  logic [127:0] req0_key_i,
  input  logic [127:0] req0_data_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [1:0]   req1_op_i,
  input  logic [127:0] req1_key_i,
  input  logic [127:0] req1_data_i,
  output logic         rsp0_valid_o,
  input  logic         rsp0_ready_i,
  output logic [127:0] rsp0_result_o,
  output logic         rsp0_err_o,
  output logic         rsp1_valid_o,
  input  logic         rsp1_ready_i,
  output logic [127:0] rsp1_result_o,
  output logic         rsp1_err_o,
  output logic         core_start_o,
  output logic [1:0]   core_op_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_data_o,
  input  logic [127:0] core_result_i,
  input  logic         core_valid_i,
  input  logic         core_ready_i
);

  // state | meaning
  // IDLE  | waiting for a valid requester while the core is ready
  // ISSUE | one-cycle core_start_o pulse with the captured job
  // WAIT  | job running in the core, waiting for core_valid_i
  // RESP  | result presented to the owner until it accepts it
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state_q, state_d;
  logic         ptr_q;
  logic         owner_q;
  logic [1:0]   op_q;
  logic [127:0] key_q;
  logic [127:0] data_q;
  logic [127:0] result_q;
  logic         grant;
  logic         grant_sel;
  logic         rsp_ready_sel;
  logic         timeout;
  logic         wait_done;

  // Pointer picks first; the other requester wins only if the preferred one is idle.
  always_comb begin
    grant_sel = 1'b0;
    if (ptr_q) grant_sel = req1_valid_i ? 1'b1 : 1'b0;
    else       grant_sel = req0_valid_i ? 1'b0 : 1'b1;
  end

  // rst_n_i in the grant term keeps the ready outputs low while reset is held.
  assign grant = rst_n_i && (state_q == IDLE) && core_ready_i &&
                 (req0_valid_i || req1_valid_i);

  assign req0_ready_o  = grant && !grant_sel;
  assign req1_ready_o  = grant &&  grant_sel;
  assign rsp_ready_sel = owner_q ? rsp1_ready_i : rsp0_ready_i;
  assign wait_done     = (state_q == WAIT) && (core_valid_i || timeout);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    core_start_o = 1'b0;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: begin
        core_start_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT:  if (core_valid_i || timeout) state_d = RESP;
      RESP:  if (rsp_ready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= '0;
      key_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_sel;
        ptr_q   <= ~grant_sel;
        op_q    <= grant_sel ? req1_op_i   : req0_op_i;
        key_q   <= grant_sel ? req1_key_i  : req0_key_i;
        data_q  <= grant_sel ? req1_data_i : req0_data_i;
      end
      // A timeout without core_valid_i returns an all-zero result.
      if (wait_done) result_q <= core_valid_i ? core_result_i : '0;
    end
  end

`ifdef AES128_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Loaded in ISSUE so terminal count lands on the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)                     cnt_q <= CNT_LOAD;
      else if (state_q == WAIT && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
      if (wait_done) err_q <= !core_valid_i;
    end
  end

  assign timeout    = (state_q == WAIT) && (cnt_q == '0);
  assign rsp0_err_o = rsp0_valid_o && err_q;
  assign rsp1_err_o = rsp1_valid_o && err_q;
`else
  assign timeout    = 1'b0;
  assign rsp0_err_o = 1'b0;
  assign rsp1_err_o = 1'b0;

  // TIMEOUT_CYCLES has no effect when the counter is not built.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_cycles_unused
  end
`endif

  assign core_op_o   = op_q;
  assign core_key_o  = key_q;
  assign core_data_o = data_q;

  assign rsp0_valid_o  = (state_q == RESP) && !owner_q;
  assign rsp1_valid_o  = (state_q == RESP) &&  owner_q;
  assign rsp0_result_o = owner_q ? '0 : result_q;
  assign rsp1_result_o = owner_q ? result_q : '0;

endmodule

// File: tb/tb_aes128_arbiter.sv
// Directed scoreboard bench for aes128_arbiter with a behavioural AES core model.
module tb_aes128_arbiter;
  localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [1:0] req0_op_i, req1_op_i, core_op_o;
  logic [127:0] req0_key_i, req0_data_i, req1_key_i, req1_data_i;
  logic rsp0_valid_o, rsp0_ready_i, rsp0_err_o, rsp1_valid_o, rsp1_ready_i, rsp1_err_o;
  logic [127:0] rsp0_result_o, rsp1_result_o;
  logic core_start_o, core_valid_i, core_ready_i;
  logic [127:0] core_key_o, core_data_o, core_result_i;

  always #5 clk_i = ~clk_i;

  aes128_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_key_i(req0_key_i), .req0_data_i(req0_data_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_key_i(req1_key_i), .req1_data_i(req1_data_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp0_result_o(rsp0_result_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_result_o(rsp1_result_o), .rsp1_err_o(rsp1_err_o),
    .core_start_o(core_start_o), .core_op_o(core_op_o), .core_key_o(core_key_o),
    .core_data_o(core_data_o), .core_result_i(core_result_i),
    .core_valid_i(core_valid_i), .core_ready_i(core_ready_i)
  );

  typedef struct {
    logic         owner;
    logic [127:0] result;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  bit core_en = 1'b1;
  bit spur = 1'b0;
  int core_lat = 2;
  bit core_pend = 1'b0;
  int core_cnt = 0;
  logic [127:0] core_res = '0;

  // Known FIPS-197 vector in both directions, otherwise a cheap reversible mix.
  function automatic logic [127:0] core_fn(input logic [1:0] op, input logic [127:0] key,
                                           input logic [127:0] data);
    if (op == 2'b00 && key == K && data == P) return C;
    if (op == 2'b01 && key == K && data == C) return P;
    return key ^ {data[63:0], data[127:64]} ^ {126'b0, op};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic outs_or();
    return |{req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o,
             rsp0_result_o, rsp1_result_o, core_start_o, core_op_o, core_key_o, core_data_o};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input bit n, input logic [1:0] op, input logic [127:0] key,
                         input logic [127:0] data);
    if (n) begin
      req1_op_i = op; req1_key_i = key; req1_data_i = data; req1_valid_i = 1'b1;
    end else begin
      req0_op_i = op; req0_key_i = key; req0_data_i = data; req0_valid_i = 1'b1;
    end
    #1;
  endtask

  task automatic await_grant(input bit n, input string tag);
    int i;
    i = 0;
    while (!(n ? req1_ready_o : req0_ready_o) && i < 100) begin
      @(negedge clk_i);
      i++;
    end
    check(tag, n ? req1_ready_o : req0_ready_o, 1);
    check({tag, "_excl"}, n ? req0_ready_o : req1_ready_o, 0);
  endtask

  // mode 0: normal result expected, 1: timeout result expected, 2: no response expected
  task automatic issue_phase(input bit n, input int mode, input bit keep);
    logic [1:0] op;
    logic [127:0] key, data;
    exp_t e;
    op = n ? req1_op_i : req0_op_i;
    key = n ? req1_key_i : req0_key_i;
    data = n ? req1_data_i : req0_data_i;
    e.owner = n;
    e.result = (mode == 1) ? '0 : core_fn(op, key, data);
    e.err = (mode == 1);
    if (mode != 2) sb.push_back(e);
    @(negedge clk_i);
    if (!keep) begin
      if (n) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    end
    check("start_high", core_start_o, 1);
    check("core_op", core_op_o, op);
    check("core_key", core_key_o, key);
    check("core_data", core_data_o, data);
    check("no_ready_issue", req0_ready_o | req1_ready_o, 0);
    @(negedge clk_i);
    check("start_low", core_start_o, 0);
  endtask

  task automatic await_rsp(input string tag, output int waited, output exp_t e);
    waited = 0;
    while (!(rsp0_valid_o || rsp1_valid_o) && waited < 400) begin
      @(negedge clk_i);
      waited++;
    end
    check({tag, "_valid"}, rsp0_valid_o | rsp1_valid_o, 1);
    check({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.owner = 1'b0; e.result = '0; e.err = 1'b0;
    end
    check({tag, "_owner"}, rsp1_valid_o, e.owner);
    check({tag, "_other"}, e.owner ? rsp0_valid_o : rsp1_valid_o, 0);
    check({tag, "_result"}, e.owner ? rsp1_result_o : rsp0_result_o, e.result);
    check({tag, "_err"}, e.owner ? rsp1_err_o : rsp0_err_o, e.err);
    check({tag, "_no_grant"}, req0_ready_o | req1_ready_o, 0);
  endtask

  task automatic ack(input bit n);
    if (n) rsp1_ready_i = 1'b1; else rsp0_ready_i = 1'b1;
    @(negedge clk_i);
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    check("rsp_drop", n ? rsp1_valid_o : rsp0_valid_o, 0);
  endtask

  // Core model: result appears core_lat+1 cycles into WAIT, for one cycle.
  initial begin
    core_valid_i = 1'b0;
    core_result_i = '0;
    forever begin
      @(negedge clk_i);
      core_valid_i = 1'b0;
      if (spur) begin
        core_valid_i = 1'b1;
        core_result_i = {4{32'hdeadbeef}};
      end
      if (!rst_n_i) core_pend = 1'b0;
      else if (core_pend) begin
        if (core_cnt == 0) begin
          core_valid_i = 1'b1;
          core_result_i = core_res;
          core_pend = 1'b0;
        end else core_cnt--;
      end
      if (core_start_o && core_en) begin
        core_pend = 1'b1;
        core_cnt = core_lat;
        core_res = core_fn(core_op_o, core_key_o, core_data_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    exp_t e;
    bit seen;
    bit exp_n;
    int i;

    // Reset: all outputs low even with requests and ready core present.
    rst_n_i = 1'b0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1; core_ready_i = 1'b1;
    set_job(0, 2'b00, rnd128(), rnd128());
    set_job(1, 2'b01, rnd128(), rnd128());
    repeat (3) @(negedge clk_i);
    check("rst_outputs", outs_or(), 0);
    check("rst_ready0", req0_ready_o, 0);
    check("rst_start", core_start_o, 0);

    // FIPS-197 encrypt from req0; grant available right at reset release.
    req1_valid_i = 1'b0; rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    set_job(0, 2'b00, K, P);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check("first_grant", req0_ready_o, 1);
    check("first_grant_excl", req1_ready_o, 0);
    check("first_grant_nostart", core_start_o, 0);
    issue_phase(0, 0, 0);
    await_rsp("vec_enc", waited, e);
    check("vec_enc_latency", waited, 3);
    check("vec_enc_cipher", rsp0_result_o, C);
    ack(0);

    // Stray core_valid in IDLE, then req1 decrypt with an early rsp ready pulse.
    spur = 1'b1;
    repeat (2) @(negedge clk_i);
    spur = 1'b0;
    @(negedge clk_i);
    check("spur_ignored", rsp0_valid_o | rsp1_valid_o, 0);
    core_lat = 4;
    set_job(1, 2'b01, K, C);
    await_grant(1, "dec_grant");
    issue_phase(1, 0, 0);
    rsp1_ready_i = 1'b1;
    @(negedge clk_i);
    rsp1_ready_i = 1'b0;
    await_rsp("dec", waited, e);
    check("dec_plain", rsp1_result_o, P);
    ack(1);

    // Response held for 10 cycles; then core_ready low blocks the next grant.
    core_lat = 1;
    set_job(0, 2'b00, rnd128(), rnd128());
    await_grant(0, "hold_grant");
    issue_phase(0, 0, 0);
    await_rsp("hold", waited, e);
    set_job(1, 2'b01, rnd128(), rnd128());
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("hold_valid", rsp0_valid_o, 1);
      check("hold_result", rsp0_result_o, e.result);
      check("hold_no_grant", req1_ready_o, 0);
    end
    core_ready_i = 1'b0;
    ack(0);
    check("core_busy_no_grant", req1_ready_o, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("core_busy_no_grant", req1_ready_o, 0);
    end
    core_ready_i = 1'b1;
    #1;
    check("core_ready_grant", req1_ready_o, 1);
    issue_phase(1, 0, 0);
    await_rsp("after_hold", waited, e);
    ack(1);

`ifdef AES128_ARB_TIMEOUT_EN
    // Core never answers: error response after 8 WAIT cycles.
    core_en = 1'b0;
    set_job(0, 2'b00, rnd128(), rnd128());
    await_grant(0, "to_grant");
    issue_phase(0, 1, 0);
    check("to_wait", rsp0_valid_o, 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      check("to_wait", rsp0_valid_o, 0);
    end
    @(negedge clk_i);
    await_rsp("timeout", waited, e);
    check("to_latency", waited, 0);
    ack(0);
    core_en = 1'b1;
`endif

    // Reset pulsed during WAIT clears everything, including the pointer.
    core_en = 1'b0;
    set_job(0, 2'b00, rnd128(), rnd128());
    await_grant(0, "rst_grant");
    issue_phase(0, 2, 0);
`ifndef AES128_ARB_TIMEOUT_EN
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk_i);
      seen = seen | rsp0_valid_o | rsp1_valid_o;
    end
    check("wait_persists", seen, 0);
`else
    @(negedge clk_i);
`endif
    set_job(1, 2'b01, rnd128(), rnd128());
    rst_n_i = 1'b0;
    #1;
    check("rst_mid_outputs", outs_or(), 0);
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    rst_n_i = 1'b1;
    core_en = 1'b1;
    core_lat = 2;

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    set_job(0, 2'b00, rnd128(), rnd128());
    set_job(1, 2'b01, rnd128(), rnd128());
    for (int j = 0; j < 4; j++) begin
      exp_n = (j % 2) == 1;
      i = 0;
      while (!(req0_ready_o || req1_ready_o) && i < 100) begin
        @(negedge clk_i);
        i++;
      end
      check("alt_grant", {req1_ready_o, req0_ready_o}, exp_n ? 2'b10 : 2'b01);
      issue_phase(exp_n, 0, 1);
      set_job(exp_n, exp_n ? 2'b01 : 2'b00, rnd128(), rnd128());
      await_rsp("alt", waited, e);
      ack(exp_n);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(negedge clk_i);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
